// File: rtl/memory_access_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nyuzi_defs (package)
//  Description : Shared decode constants, memory op encodings, control
//                register indices and cache geometry for the memory access
//                stage and its store mask generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package nyuzi_defs;

  localparam int LINE_BYTES = 64;
  localparam int LANES      = 16;

  // Format C (memory) instructions have these top two bits
  localparam logic [1:0] C_FMT_C = 2'b10;

  // Memory operation types held in instruction bits [28:25]
  typedef enum logic [3:0] {
    C_OP_BYTE         = 4'b0000,
    C_OP_BYTE_SEXT    = 4'b0001,
    C_OP_SHORT        = 4'b0010,
    C_OP_SHORT_SEXT   = 4'b0011,
    C_OP_WORD         = 4'b0100,
    C_OP_WORD_SYNC    = 4'b0101,
    C_OP_CONTROL_REG  = 4'b0110,
    C_OP_BLOCK        = 4'b0111,
    C_OP_BLOCK_M      = 4'b1000,
    C_OP_BLOCK_IM     = 4'b1001,
    C_OP_STRIDED      = 4'b1010,
    C_OP_STRIDED_M    = 4'b1011,
    C_OP_STRIDED_IM   = 4'b1100,
    C_OP_SCGATH       = 4'b1101,
    C_OP_SCGATH_M     = 4'b1110,
    C_OP_SCGATH_IM    = 4'b1111
  } mem_op_t;

  // Control register indices
  localparam logic [4:0] C_CR_STRAND_ID = 5'd0;
  localparam logic [4:0] C_CR_USER1     = 5'd1;
  localparam logic [4:0] C_CR_USER2     = 5'd2;
  localparam logic [4:0] C_CR_USER3     = 5'd3;

  // Byte enables for one 32-bit word of the line; bit 63 is byte 0
  function automatic logic [63:0] word_enable(input logic [3:0] word);
    return 64'hF000_0000_0000_0000 >> {word, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/memory_access_stage_store_mask_gen.sv
`default_nettype none
// ============================================================================
//  Module      : store_mask_gen
//  Description : Combinational store data and 64-bit byte-enable generation
//                for scalar, block, strided and scatter stores.
//                Byte 0 of the line is ddata[511:504] / enable bit 63;
//                lane 0 of a vector is bits [511:480] / mask bit 15.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_mask_gen
  import nyuzi_defs::*;
(
  input  logic          enable_i,
  input  mem_op_t       op_type_i,
  input  logic [5:0]    offset_i,
  input  logic [3:0]    reg_lane_select_i,
  input  logic [3:0]    cache_lane_select_i,
  input  logic [15:0]   mask_i,
  input  logic [511:0]  store_value_i,
  output logic [511:0]  ddata_o,
  output logic [63:0]   byte_enable_o
);

  logic [31:0] w_lanes [LANES];
  logic [31:0] w_lane_value;
  logic [63:0] w_be;

  // Split the store vector into lanes, lane 0 in the most significant word
  generate
    for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign w_lanes[g] = store_value_i[511 - 32*g -: 32];
    end
  endgenerate

  assign w_lane_value = w_lanes[reg_lane_select_i];

  // Select store data layout and enables from the op type
  always_comb begin
    ddata_o = store_value_i;
    w_be    = '0;
    case (op_type_i)
      C_OP_BYTE, C_OP_BYTE_SEXT: begin
        ddata_o = {LINE_BYTES{store_value_i[7:0]}};
        w_be    = 64'h8000_0000_0000_0000 >> offset_i;
      end
      C_OP_SHORT, C_OP_SHORT_SEXT: begin
        // Low offset bit is dropped so a short never straddles its pair
        ddata_o = {(LINE_BYTES / 2){store_value_i[15:0]}};
        w_be    = 64'hC000_0000_0000_0000 >> {offset_i[5:1], 1'b0};
      end
      C_OP_WORD, C_OP_WORD_SYNC: begin
        ddata_o = {LANES{store_value_i[31:0]}};
        w_be    = word_enable(offset_i[5:2]);
      end
      C_OP_BLOCK, C_OP_BLOCK_M, C_OP_BLOCK_IM: begin
        ddata_o = store_value_i;
        for (int l = 0; l < LANES; l++) begin
          w_be[63 - 4*l -: 4] = {4{mask_i[15 - l]}};
        end
      end
      C_OP_STRIDED, C_OP_STRIDED_M, C_OP_STRIDED_IM,
      C_OP_SCGATH, C_OP_SCGATH_M, C_OP_SCGATH_IM: begin
        // One lane per cycle: write it to the selected cache word if active
        ddata_o = {LANES{w_lane_value}};
        if (mask_i[4'd15 - reg_lane_select_i]) begin
          w_be = word_enable(cache_lane_select_i);
        end
      end
      default: begin
        ddata_o = store_value_i;
        w_be    = '0;
      end
    endcase
  end

  assign byte_enable_o = enable_i ? w_be : 64'd0;

endmodule
`default_nettype wire

// File: rtl/memory_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : memory_access_stage
//  Description : Pipeline stage after execute. Registers execute results,
//                drives the data-cache store strobe/data/byte enables and
//                services control-register transfers. Registered outputs
//                also act as the execute stage's first bypass source.
//                Optional feature macro: MEMORY_ACCESS_CONTROL_REGS_EN
//                (defined: CR1-CR3 read/write file, CR0 = STRAND_ID;
//                 undefined: all CR reads return 0, writes are ignored).
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_access_stage
  import nyuzi_defs::*;
#(
  parameter int STRAND_ID = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   instruction_i,
  output logic [31:0]   instruction_o,
  input  logic [31:0]   pc_i,
  output logic [31:0]   pc_o,
  input  logic          has_writeback_i,
  output logic          has_writeback_o,
  input  logic [4:0]    writeback_reg_i,
  output logic [4:0]    writeback_reg_o,
  input  logic          writeback_is_vector_i,
  output logic          writeback_is_vector_o,
  input  logic [15:0]   mask_i,
  output logic [15:0]   mask_o,
  input  logic [511:0]  result_i,
  output logic [511:0]  result_o,
  input  logic [511:0]  store_value_i,
  input  logic [3:0]    reg_lane_select_i,
  output logic [3:0]    reg_lane_select_o,
  input  logic [3:0]    cache_lane_select_i,
  output logic [3:0]    cache_lane_select_o,
  input  logic          was_access_i,
  output logic          was_access_o,
  input  logic          flush_i,
  output logic          dwrite_o,
  output logic [511:0]  ddata_o,
  output logic [63:0]   dwrite_mask_o
);

  logic        w_is_fmt_c;
  logic        w_is_load;
  mem_op_t     w_op_type;
  logic [4:0]  w_cr_index;
  logic        w_is_cr_op;
  logic        w_cr_write;
  logic        w_cr_read;
  logic [31:0] w_cr_read_value;
  logic [511:0] w_next_result;

  // Instruction decode
  assign w_is_fmt_c = (instruction_i[31:30] == C_FMT_C);
  assign w_is_load  = instruction_i[29];
  assign w_op_type  = mem_op_t'(instruction_i[28:25]);
  assign w_cr_index = instruction_i[14:10];
  assign w_is_cr_op = w_is_fmt_c && (w_op_type == C_OP_CONTROL_REG);
  assign w_cr_write = w_is_cr_op && !w_is_load && !flush_i;
  assign w_cr_read  = w_is_cr_op && w_is_load;

  // Store strobe; held low during reset so a half-issued store never lands
  assign dwrite_o = w_is_fmt_c && !w_is_load && (w_op_type != C_OP_CONTROL_REG)
                    && was_access_i && !flush_i && !reset;

  store_mask_gen u_store_mask_gen (
    .enable_i            (dwrite_o),
    .op_type_i           (w_op_type),
    .offset_i            (result_i[5:0]),
    .reg_lane_select_i   (reg_lane_select_i),
    .cache_lane_select_i (cache_lane_select_i),
    .mask_i              (mask_i),
    .store_value_i       (store_value_i),
    .ddata_o             (ddata_o),
    .byte_enable_o       (dwrite_mask_o)
  );

`ifdef MEMORY_ACCESS_CONTROL_REGS_EN
  logic [31:0] r_cr [1:3];

  // Control register file write port; flush suppresses the write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cr[1] <= '0;
      r_cr[2] <= '0;
      r_cr[3] <= '0;
    end else if (w_cr_write) begin
      case (w_cr_index)
        C_CR_USER1: r_cr[1] <= store_value_i[31:0];
        C_CR_USER2: r_cr[2] <= store_value_i[31:0];
        C_CR_USER3: r_cr[3] <= store_value_i[31:0];
        default:    ;
      endcase
    end
  end

  // Control register read mux; unimplemented indices read as zero
  always_comb begin
    w_cr_read_value = '0;
    case (w_cr_index)
      C_CR_STRAND_ID: w_cr_read_value = 32'(STRAND_ID);
      C_CR_USER1:     w_cr_read_value = r_cr[1];
      C_CR_USER2:     w_cr_read_value = r_cr[2];
      C_CR_USER3:     w_cr_read_value = r_cr[3];
      default:        w_cr_read_value = '0;
    endcase
  end
`else
  logic w_unused_cr;

  // No CR storage: reads return zero and write decode goes nowhere
  assign w_cr_read_value = '0;
  assign w_unused_cr     = ^{w_cr_write, w_cr_index, 32'(STRAND_ID)};
`endif

  assign w_next_result = w_cr_read ? {480'd0, w_cr_read_value} : result_i;

  // Pipeline register; flush loads a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instruction_o         <= '0;
      pc_o                  <= '0;
      has_writeback_o       <= 1'b0;
      writeback_reg_o       <= '0;
      writeback_is_vector_o <= 1'b0;
      mask_o                <= '0;
      result_o              <= '0;
      reg_lane_select_o     <= '0;
      cache_lane_select_o   <= '0;
      was_access_o          <= 1'b0;
    end else if (flush_i) begin
      instruction_o         <= '0;
      pc_o                  <= '0;
      has_writeback_o       <= 1'b0;
      writeback_reg_o       <= '0;
      writeback_is_vector_o <= 1'b0;
      mask_o                <= '0;
      result_o              <= '0;
      reg_lane_select_o     <= '0;
      cache_lane_select_o   <= '0;
      was_access_o          <= 1'b0;
    end else begin
      instruction_o         <= instruction_i;
      pc_o                  <= pc_i;
      has_writeback_o       <= has_writeback_i;
      writeback_reg_o       <= writeback_reg_i;
      writeback_is_vector_o <= writeback_is_vector_i;
      mask_o                <= mask_i;
      result_o              <= w_next_result;
      reg_lane_select_o     <= reg_lane_select_i;
      cache_lane_select_o   <= cache_lane_select_i;
      was_access_o          <= was_access_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_access_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_access_stage
//  Description : Self-checking bench for memory_access_stage. Combinational
//                store outputs are checked against directed expectations;
//                registered outputs are predicted into a scoreboard queue
//                and compared one cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_access_stage;

  localparam int STRAND = 7;
`ifdef MEMORY_ACCESS_CONTROL_REGS_EN
  localparam bit CR_EN = 1'b1;
`else
  localparam bit CR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   instruction_i, instruction_o;
  logic [31:0]   pc_i, pc_o;
  logic          has_writeback_i, has_writeback_o;
  logic [4:0]    writeback_reg_i, writeback_reg_o;
  logic          writeback_is_vector_i, writeback_is_vector_o;
  logic [15:0]   mask_i, mask_o;
  logic [511:0]  result_i, result_o;
  logic [511:0]  store_value_i;
  logic [3:0]    reg_lane_select_i, reg_lane_select_o;
  logic [3:0]    cache_lane_select_i, cache_lane_select_o;
  logic          was_access_i, was_access_o;
  logic          flush_i;
  logic          dwrite_o;
  logic [511:0]  ddata_o;
  logic [63:0]   dwrite_mask_o;

  memory_access_stage #(.STRAND_ID(STRAND)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .instruction_i         (instruction_i),
    .instruction_o         (instruction_o),
    .pc_i                  (pc_i),
    .pc_o                  (pc_o),
    .has_writeback_i       (has_writeback_i),
    .has_writeback_o       (has_writeback_o),
    .writeback_reg_i       (writeback_reg_i),
    .writeback_reg_o       (writeback_reg_o),
    .writeback_is_vector_i (writeback_is_vector_i),
    .writeback_is_vector_o (writeback_is_vector_o),
    .mask_i                (mask_i),
    .mask_o                (mask_o),
    .result_i              (result_i),
    .result_o              (result_o),
    .store_value_i         (store_value_i),
    .reg_lane_select_i     (reg_lane_select_i),
    .reg_lane_select_o     (reg_lane_select_o),
    .cache_lane_select_i   (cache_lane_select_i),
    .cache_lane_select_o   (cache_lane_select_o),
    .was_access_i          (was_access_i),
    .was_access_o          (was_access_o),
    .flush_i               (flush_i),
    .dwrite_o              (dwrite_o),
    .ddata_o               (ddata_o),
    .dwrite_mask_o         (dwrite_mask_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]  inst;
    logic [31:0]  pc;
    logic         hw;
    logic [4:0]   wr;
    logic         vec;
    logic [15:0]  msk;
    logic [511:0] res;
    logic [3:0]   rl;
    logic [3:0]   cl;
    logic         wa;
  } exp_t;

  exp_t         sb[$];
  logic [31:0]  cr_model [1:3];
  logic [511:0] sv_pat;
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] fmt_c(input logic load, input logic [3:0] op, input logic [4:0] idx);
    return {2'b10, load, op, 10'd0, idx, 10'd0};
  endfunction

  function automatic logic [31:0] cr_read_model(input logic [4:0] idx);
    if (!CR_EN) return 32'd0;
    case (idx)
      5'd0:    return 32'(STRAND);
      5'd1:    return cr_model[1];
      5'd2:    return cr_model[2];
      5'd3:    return cr_model[3];
      default: return 32'd0;
    endcase
  endfunction

  task automatic set_in(input logic [31:0] inst, input logic [31:0] pc, input logic [511:0] res,
                        input logic [511:0] sv, input logic [15:0] msk, input logic [3:0] rl,
                        input logic [3:0] cl, input logic wa, input logic fl);
    instruction_i         = inst;
    pc_i                  = pc;
    has_writeback_i       = inst[29];
    writeback_reg_i       = pc[4:0];
    writeback_is_vector_i = pc[5];
    result_i              = res;
    store_value_i         = sv;
    mask_i                = msk;
    reg_lane_select_i     = rl;
    cache_lane_select_i   = cl;
    was_access_i          = wa;
    flush_i               = fl;
  endtask

  // Check combinational outputs, predict the registered ones, clock, compare
  task automatic run_cycle(input string tag, input logic exp_dw, input logic [63:0] exp_be,
                           input logic [511:0] exp_dd, input logic chk_dd);
    exp_t e;
    exp_t g;
    logic is_cr;
    #1;
    check({tag, ".dwrite"}, 512'(dwrite_o), 512'(exp_dw));
    check({tag, ".dmask"}, 512'(dwrite_mask_o), 512'(exp_be));
    if (chk_dd) check({tag, ".ddata"}, ddata_o, exp_dd);
    is_cr = (instruction_i[31:30] == 2'b10) && (instruction_i[28:25] == 4'b0110);
    e = '0;
    if (!flush_i) begin
      e.inst = instruction_i;
      e.pc   = pc_i;
      e.hw   = has_writeback_i;
      e.wr   = writeback_reg_i;
      e.vec  = writeback_is_vector_i;
      e.msk  = mask_i;
      e.res  = (is_cr && instruction_i[29]) ? {480'd0, cr_read_model(instruction_i[14:10])} : result_i;
      e.rl   = reg_lane_select_i;
      e.cl   = cache_lane_select_i;
      e.wa   = was_access_i;
      if (is_cr && !instruction_i[29]) begin
        case (instruction_i[14:10])
          5'd1: cr_model[1] = store_value_i[31:0];
          5'd2: cr_model[2] = store_value_i[31:0];
          5'd3: cr_model[3] = store_value_i[31:0];
          default: ;
        endcase
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    check({tag, ".inst"}, 512'(instruction_o), 512'(g.inst));
    check({tag, ".pc"}, 512'(pc_o), 512'(g.pc));
    check({tag, ".wb"}, 512'({has_writeback_o, writeback_reg_o, writeback_is_vector_o}),
          512'({g.hw, g.wr, g.vec}));
    check({tag, ".mask_o"}, 512'(mask_o), 512'(g.msk));
    check({tag, ".result"}, result_o, g.res);
    check({tag, ".lanes"}, 512'({reg_lane_select_o, cache_lane_select_o}), 512'({g.rl, g.cl}));
    check({tag, ".was_access"}, 512'(was_access_o), 512'(g.wa));
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int l = 0; l < 16; l++) sv_pat[511 - 32*l -: 32] = 32'hC0DE_0000 | 32'(l);
    cr_model[1] = '0; cr_model[2] = '0; cr_model[3] = '0;
    reset = 1'b1;
    set_in(32'h0, 32'h0, '0, '0, 16'h0, 4'd0, 4'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset.dwrite", 512'(dwrite_o), 512'd0);
    check("reset.result", result_o, 512'd0);
    check("reset.pc", 512'(pc_o), 512'd0);
    check("reset.was_access", 512'(was_access_o), 512'd0);
    reset = 1'b0;
    @(negedge clk);

    // Scalar byte store at offset 5
    set_in(fmt_c(1'b0, 4'b0000, 5'd0), 32'h100, 512'd5, 512'hAB, 16'hFFFF, 4'd0, 4'd0, 1'b1, 1'b0);
    run_cycle("byte_off5", 1'b1, 64'd1 << 58, {64{8'hAB}}, 1'b1);
    // Byte at the line boundary
    set_in(fmt_c(1'b0, 4'b0001, 5'd0), 32'h104, 512'd63, sv_pat, 16'hFFFF, 4'd0, 4'd0, 1'b1, 1'b0);
    run_cycle("byte_off63", 1'b1, 64'd1, {64{8'h0F}}, 1'b1);
    // Misaligned short at 63 covers bytes 62-63
    set_in(fmt_c(1'b0, 4'b0010, 5'd0), 32'h108, 512'd63, sv_pat, 16'hFFFF, 4'd0, 4'd0, 1'b1, 1'b0);
    run_cycle("short_off63", 1'b1, 64'h3, {32{16'h000F}}, 1'b1);
    // Word at offset 9 covers bytes 8-11
    set_in(fmt_c(1'b0, 4'b0100, 5'd0), 32'h10C, 512'd9, sv_pat, 16'hFFFF, 4'd0, 4'd0, 1'b1, 1'b0);
    run_cycle("word_off9", 1'b1, 64'h00F0_0000_0000_0000, {16{32'hC0DE000F}}, 1'b1);
    // Block store with lanes 0 and 15
    set_in(fmt_c(1'b0, 4'b0111, 5'd0), 32'h110, 512'd0, sv_pat, 16'h8001, 4'd0, 4'd0, 1'b1, 1'b0);
    run_cycle("block", 1'b1, 64'hF000_0000_0000_000F, sv_pat, 1'b1);
    // Scatter lane 3 to cache word 9, lane active then inactive
    set_in(fmt_c(1'b0, 4'b1101, 5'd0), 32'h114, 512'd0, sv_pat, 16'h1000, 4'd3, 4'd9, 1'b1, 1'b0);
    run_cycle("scatter_on", 1'b1, 64'h0000_0000_0F00_0000, {16{32'hC0DE0003}}, 1'b1);
    set_in(fmt_c(1'b0, 4'b1010, 5'd0), 32'h118, 512'd0, sv_pat, 16'hEFFF, 4'd3, 4'd9, 1'b1, 1'b0);
    run_cycle("scatter_off", 1'b1, 64'd0, '0, 1'b0);
    // Load and non-access store never strobe
    set_in(fmt_c(1'b1, 4'b0000, 5'd0), 32'h11C, 512'h1234, sv_pat, 16'hFFFF, 4'd0, 4'd0, 1'b1, 1'b0);
    run_cycle("load", 1'b0, 64'd0, '0, 1'b0);
    set_in(fmt_c(1'b0, 4'b0100, 5'd0), 32'h120, 512'h4, sv_pat, 16'hFFFF, 4'd0, 4'd0, 1'b0, 1'b0);
    run_cycle("no_access", 1'b0, 64'd0, '0, 1'b0);

    // Control registers
    set_in(fmt_c(1'b0, 4'b0110, 5'd2), 32'h124, '0, 512'hDEADBEEF, 16'hFFFF, 4'd0, 4'd0, 1'b1, 1'b0);
    run_cycle("cr2_wr", 1'b0, 64'd0, '0, 1'b0);
    set_in(fmt_c(1'b1, 4'b0110, 5'd2), 32'h128, 512'h55, '0, 16'hFFFF, 4'd0, 4'd0, 1'b1, 1'b0);
    run_cycle("cr2_rd", 1'b0, 64'd0, '0, 1'b0);
    check("cr2_rd_value", 512'(result_o[31:0]), CR_EN ? 512'h0DEADBEEF : 512'd0);
    set_in(fmt_c(1'b1, 4'b0110, 5'd0), 32'h12C, 512'h55, '0, 16'hFFFF, 4'd0, 4'd0, 1'b1, 1'b0);
    run_cycle("cr0_rd", 1'b0, 64'd0, '0, 1'b0);
    check("cr0_value", result_o, CR_EN ? 512'(STRAND) : 512'd0);
    set_in(fmt_c(1'b0, 4'b0110, 5'd1), 32'h130, '0, 512'h11111111, 16'hFFFF, 4'd0, 4'd0, 1'b1, 1'b0);
    run_cycle("cr1_wr", 1'b0, 64'd0, '0, 1'b0);

    // Flush during a store, then during a CR1 write
    set_in(fmt_c(1'b0, 4'b0000, 5'd0), 32'h134, 512'd5, sv_pat, 16'hFFFF, 4'd1, 4'd2, 1'b1, 1'b1);
    run_cycle("flush_store", 1'b0, 64'd0, '0, 1'b0);
    set_in(fmt_c(1'b0, 4'b0110, 5'd1), 32'h138, '0, 512'h22222222, 16'hFFFF, 4'd0, 4'd0, 1'b1, 1'b1);
    run_cycle("flush_cr1", 1'b0, 64'd0, '0, 1'b0);
    set_in(fmt_c(1'b1, 4'b0110, 5'd1), 32'h13C, '0, '0, 16'hFFFF, 4'd0, 4'd0, 1'b0, 1'b0);
    run_cycle("cr1_rd", 1'b0, 64'd0, '0, 1'b0);
    check("cr1_value", 512'(result_o[31:0]), CR_EN ? 512'h11111111 : 512'd0);

    // Asynchronous reset in the middle of a store
    set_in(fmt_c(1'b0, 4'b0100, 5'd0), 32'h140, 512'd4, sv_pat, 16'hFFFF, 4'd0, 4'd0, 1'b1, 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("areset.dwrite", 512'(dwrite_o), 512'd0);
    check("areset.dmask", 512'(dwrite_mask_o), 512'd0);
    check("areset.pc", 512'(pc_o), 512'd0);
    check("areset.result", result_o, 512'd0);
    check("areset.was_access", 512'(was_access_o), 512'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cr_model[1] = '0; cr_model[2] = '0; cr_model[3] = '0;
    for (int i = 1; i <= 3; i++) begin
      set_in(fmt_c(1'b1, 4'b0110, 5'(i)), 32'h200 + 32'(i), 512'hFF, '0, 16'h0, 4'd0, 4'd0, 1'b0, 1'b0);
      run_cycle("post_reset_cr", 1'b0, 64'd0, '0, 1'b0);
      check("post_reset_cr_value", result_o, 512'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/memory_access_stage.md
# memory_access_stage

Pipeline stage directly downstream of the execute stage. It registers the execute results, forms the data-cache store data and the 64-bit byte-enable mask for scalar, block, strided and scatter stores, and services control-register transfers. Its registered outputs feed the writeback stage and also serve as the execute stage's first bypass source (bypass1).

## Interface
Parameters:
- STRAND_ID, default 0: value returned on reads of CR0.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- instruction_i / instruction_o  in/out  32  instruction
- pc_i / pc_o  in/out  32  program counter
- has_writeback_i / has_writeback_o  in/out  1  result is written back
- writeback_reg_i / writeback_reg_o  in/out  5  destination register
- writeback_is_vector_i / writeback_is_vector_o  in/out  1  destination is a vector register
- mask_i / mask_o  in/out  16  lane mask; bit 15 is lane 0
- result_i / result_o  in/out  512  ALU result; for memory ops, bits [5:0] are the address offset
- store_value_i  in  512  store data
- reg_lane_select_i / reg_lane_select_o  in/out  4  register lane for strided and scatter/gather ops
- cache_lane_select_i / cache_lane_select_o  in/out  4  cache word index
- was_access_i / was_access_o  in/out  1  execute stage issued a cache access
- flush_i  in  1  squash the instruction in this stage
- dwrite_o  out  1  store strobe to the data cache
- ddata_o  out  512  store data
- dwrite_mask_o  out  64  byte enables; bit 63 is byte 0 (bits 511:504)

## Operation
Decoding:
- Format C: instruction_i[31:30]=10.
- Load when instruction_i[29]=1.
- c_op_type = instruction_i[28:25].

Store strobe:
- dwrite_o = fmtC & !load & c_op_type≠0110 & was_access_i & !flush_i.
- dwrite_o is combinational, in the same cycle as the inputs.

Store data and byte enables, by c_op_type:
- Scalar stores, with off = result_i[5:0]:
  - 0000/0001 byte: ddata = store_value_i[7:0] replicated 64×; enable bit 63-off.
  - 0010/0011 short: [15:0] replicated 32×; enable bytes off, off+1 (off[0] ignored).
  - 0100/0101 word: [31:0] replicated 16×; enable bytes 4·off[5:2]..+3.
- 0111/1000/1001 block: ddata = store_value_i. Word L is enabled when mask_i[15-L]=1.
- 1010-1111 strided and scatter/gather:
  - ddata = lane reg_lane_select_i of store_value_i, replicated 16×.
  - Enable only word cache_lane_select_i, and only if mask_i[15-reg_lane_select_i]=1.
- When dwrite_o=0, dwrite_mask_o=0 and ddata_o is don't-care.

Control registers (c_op_type 0110):
- Index = instruction_i[14:10].
- CR0 is read-only and returns STRAND_ID.
- CR1-CR3 are 32-bit read/write.
- Indices 4-31 read 0; writes to them are ignored.
- Read (load): result_o ← {480'd0, CR[idx]}.
- Write (store): CR[idx] ← store_value_i[31:0] at the clock edge; writes are suppressed by flush_i.
- A read in the cycle after a write returns the new value.

Pass-through and flush:
- All *_o pipeline fields register their *_i counterparts.
- was_access_o registers was_access_i & !flush_i.
- flush_i=1 loads zeros into all registered outputs, writes no CR, and forces dwrite_o=0.

## Timing
- Registered outputs have 1-cycle latency; dwrite_o, ddata_o and dwrite_mask_o are combinational.
- No stall and no backpressure: one instruction is accepted every cycle.
- Reset (asynchronous): every registered output = 0; CR1-CR3 = 0.
- Reset asserted mid-store: dwrite_o is held 0 while reset=1.
- flush_i has priority over every write.
- A CR write and a flush in the same cycle: the flush wins.
- An offset at the line boundary (off=63, byte) enables only bit 0.
- A misaligned short at off=63 enables bytes 62-63.

## Configuration
- Macro MEMORY_ACCESS_CONTROL_REGS_EN.
- Defined: the CR file is implemented as above.
- Undefined: no CR storage; all CR reads return 0; CR writes are ignored; dwrite_o is still 0 for c_op_type 0110.

## Structure
- Shared package (nyuzi_defs):
  - c_op_type encodings
  - CR indices
  - format decode constants
  - LINE_BYTES=64, LANES=16
- One natural sub-module, store_mask_gen: combinational ddata and byte-enable generation from c_op_type, offset, lane selects and mask.
- The pipeline registers and the CR file live in memory_access_stage.

## Test plan
- Scalar byte store, value 0x000000AB, off=5, was_access_i=1 → dwrite_o=1, dwrite_mask_o=1<<58, ddata byte 5=0xAB.
- Block store, mask_i=0x8001 → dwrite_mask_o = 0xF00000000000000F, ddata_o = store_value_i.
- Scatter store, reg_lane 3, cache_lane 9, mask_i bit 12 set → enables bytes 36-39 holding lane 3 of store_value_i; with mask bit 12 clear → dwrite_o=1, dwrite_mask_o=0.
- CR2 write 0xDEADBEEF, then CR2 read next cycle → result_o[31:0]=0xDEADBEEF one cycle later; CR0 read → STRAND_ID.
- flush_i during a store and a CR1 write → dwrite_o=0, CR1 unchanged, all outputs 0 next cycle.
- reset asserted mid-stream → outputs 0 immediately (asynchronous); CR1-CR3 read 0 after release.
